vector_address_sequencer: RTL and testbench

//  Multi-beat, strided successor of the vector RAM address fan-out. Accepts one vector

---
 rtl/vec_mem_pkg.sv | 14 +
 rtl/lane_offset_gen.sv | 31 +++
 rtl/vector_address_sequencer.sv | 100 ++++++++++
 tb/tb_vector_address_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and default sizing for the vector memory address path.
package vec_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2
    } vas_state_t;

    localparam int VAS_LANES_DEFAULT  = 16;
    localparam int VAS_ADDR_W_DEFAULT = 32;
    localparam int VAS_VLEN_W_DEFAULT = 8;

endpackage

// File: rtl/lane_offset_gen.sv
// Combinational lane address fan-out: lane k = beat_base + k*stride (mod 2**ADDR_W).
// k*stride is built from shifted copies of stride selected by the bits of k,
// so no multiplier appears on the path.
module lane_offset_gen
    import vec_mem_pkg::*;
#(
    parameter int ADDR_W = VAS_ADDR_W_DEFAULT,
    parameter int LANES  = VAS_LANES_DEFAULT
) (
    input  logic [ADDR_W-1:0]             beat_base,
    input  logic [ADDR_W-1:0]             stride,
    output logic [LANES-1:0][ADDR_W-1:0]  lane_addr
);

    localparam int LW = $clog2(LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [LW-1:0] KIDX = LW'(k);
        logic [ADDR_W-1:0] off;

        // Shift-add of stride by the constant lane index, then offset from the beat base.
        always_comb begin
            off = '0;
            for (int j = 0; j < LW; j++) begin
                if (KIDX[j]) off = off + (stride << j);
            end
            lane_addr[k] = beat_base + off;
        end
    end

endmodule

// File: rtl/vector_address_sequencer.sv
// Turns one (base, stride, vlen) vector request into LANES-wide beats of lane
// addresses with a tail mask and valid/ready flow control. Outputs derive only
// from registered state, so they hold naturally under back-pressure.
module vector_address_sequencer
    import vec_mem_pkg::*;
#(
    parameter int ADDR_W = VAS_ADDR_W_DEFAULT,
    parameter int LANES  = VAS_LANES_DEFAULT,
    parameter int VLEN_W = VAS_VLEN_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [VLEN_W-1:0]       vlen,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ADDR_W-1:0] addr,
    output logic [LANES-1:0]        lane_mask,
    output logic                    last,
    output logic                    done
);

    localparam int LW = $clog2(LANES);

    vas_state_t                   state, state_nxt;
    logic [ADDR_W-1:0]            beat_base;
    logic [ADDR_W-1:0]            stride_r;
    logic [VLEN_W-1:0]            remaining;
    logic                         handshake;
    logic                         tail;
    logic [LANES-1:0][ADDR_W-1:0] lane_addr;

    assign handshake = out_valid && out_ready;
    // Final beat once no more than one beat's worth of elements is left.
    assign tail      = (int'(remaining) <= LANES);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: a zero-length request skips straight to FINISH so done still pulses.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (vlen != '0) ? ISSUE : FINISH;
            ISSUE:   if (handshake && tail) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; last is qualified by ISSUE so it reads 0 when idle or in reset.
    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == ISSUE);
        done      = (state == FINISH);
        last      = (state == ISSUE) && tail;
    end

    // Request latch and per-beat advance; the beat step is a shift since LANES is 2**LW.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_base <= '0;
            stride_r  <= '0;
            remaining <= '0;
        end else if (state == IDLE && start) begin
            beat_base <= base;
            stride_r  <= stride;
            remaining <= vlen;
        end else if (handshake) begin
            beat_base <= beat_base + (stride_r << LW);
            remaining <= tail ? '0 : remaining - VLEN_W'(LANES);
        end
    end

    // Tail mask: lane k carries an element while k is below the remaining count.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mask[k] = (state == ISSUE) && (k < int'(remaining));
        end
    end

    lane_offset_gen #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_lane_offset_gen (
        .beat_base (beat_base),
        .stride    (stride_r),
        .lane_addr (lane_addr)
    );

    assign addr = lane_addr;

endmodule

// File: tb/tb_vector_address_sequencer.sv
// Scoreboard bench for vector_address_sequencer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_vector_address_sequencer;

    localparam int ADDR_W = 32;
    localparam int LANES  = 16;
    localparam int VLEN_W = 8;

    typedef struct {
        logic [LANES*ADDR_W-1:0] addr;
        logic [LANES-1:0]        mask;
        logic                    last;
    } beat_t;

    logic                    clk = 0;
    logic                    rst;
    logic                    start;
    logic [ADDR_W-1:0]       base;
    logic [ADDR_W-1:0]       stride;
    logic [VLEN_W-1:0]       vlen;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*ADDR_W-1:0] addr;
    logic [LANES-1:0]        lane_mask;
    logic                    last;
    logic                    done;

    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;
    beat_t sb[$];

    logic                    hold_pending = 0;
    logic [LANES*ADDR_W-1:0] hold_addr;
    logic [LANES-1:0]        hold_mask;
    logic                    hold_last;

    vector_address_sequencer #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .VLEN_W (VLEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .stride    (stride),
        .vlen      (vlen),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addr      (addr),
        .lane_mask (lane_mask),
        .last      (last),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat b of a request: lane k = base + (b*LANES + k)*stride mod 2**32.
    task automatic push_beat(input logic [31:0] b0, input logic [31:0] st, input int b,
                             input logic [15:0] mask, input logic lst);
        beat_t e;
        for (int k = 0; k < LANES; k++) begin
            e.addr[k*ADDR_W +: ADDR_W] = b0 + 32'(b * LANES + k) * st;
        end
        e.mask = mask;
        e.last = lst;
        sb.push_back(e);
    endtask

    // One-cycle start pulse; inputs are scrambled afterwards to prove they were latched.
    task automatic start_req(input logic [31:0] b0, input logic [31:0] st, input logic [7:0] n);
        start  = 1;
        base   = b0;
        stride = st;
        vlen   = n;
        tick();
        start  = 0;
        base   = 32'hDEADBEEF;
        stride = 32'h12345678;
        vlen   = 8'hA5;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_done"}, done, 1'b1);
        tick();
        chk({name, "_done_once"}, done, 1'b0);
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    // Monitor: compare each handshaken beat against the scoreboard head, and check
    // that a stalled beat keeps its payload until it is taken.
    always @(negedge clk) begin
        if (hold_pending) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_addr", addr, hold_addr);
            chk("hold_mask", lane_mask, hold_mask);
            chk("hold_last", last, hold_last);
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", out_valid, 1'b0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_addr", addr, e.addr);
                chk("beat_mask", lane_mask, e.mask);
                chk("beat_last", last, e.last);
            end
        end
        hold_pending = !rst && out_valid && !out_ready;
        hold_addr    = addr;
        hold_mask    = lane_mask;
        hold_last    = last;
        if (done) done_cnt++;
    end

    initial begin
        rst       = 1;
        start     = 0;
        base      = '0;
        stride    = '0;
        vlen      = '0;
        out_ready = 0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", addr, '0);
        chk("rst_mask", lane_mask, '0);
        rst = 0;
        tick();

        // 1: unit stride, single full beat, one-cycle start latency
        out_ready = 1;
        push_beat(32'h100, 32'd1, 0, 16'hFFFF, 1'b1);
        start_req(32'h100, 32'd1, 8'd16);
        chk("t1_latency_valid", out_valid, 1'b1);
        chk("t1_busy", busy, 1'b1);
        wait_done("t1");
        chk("t1_sb_empty", sb.size(), 0);

        // 2: two beats with a 4-element tail
        push_beat(32'h0, 32'd4, 0, 16'hFFFF, 1'b0);
        push_beat(32'h0, 32'd4, 1, 16'h000F, 1'b1);
        start_req(32'h0, 32'd4, 8'd20);
        wait_done("t2");
        chk("t2_sb_empty", sb.size(), 0);

        // 3: back-pressure on beat0 for 3 cycles, start pulsed while busy
        out_ready = 0;
        push_beat(32'h0, 32'd4, 0, 16'hFFFF, 1'b0);
        push_beat(32'h0, 32'd4, 1, 16'h000F, 1'b1);
        start_req(32'h0, 32'd4, 8'd20);
        chk("t3_valid", out_valid, 1'b1);
        start  = 1;
        base   = 32'hCAFE0000;
        stride = 32'd3;
        vlen   = 8'd5;
        tick();
        start = 0;
        chk("t3_busy_stall", busy, 1'b1);
        tick();
        tick();
        out_ready = 1;
        wait_done("t3");
        chk("t3_sb_empty", sb.size(), 0);

        // 4: negative stride wrapping through zero
        push_beat(32'h8, 32'hFFFFFFFF, 0, 16'hFFFF, 1'b1);
        start_req(32'h8, 32'hFFFFFFFF, 8'd16);
        wait_done("t4");
        chk("t4_sb_empty", sb.size(), 0);

        // 5: zero-length request
        start_req(32'h40, 32'd1, 8'd0);
        chk("t5_busy", busy, 1'b1);
        chk("t5_done", done, 1'b1);
        chk("t5_valid", out_valid, 1'b0);
        tick();
        chk("t5_busy_after", busy, 1'b0);
        chk("t5_done_after", done, 1'b0);

        // 6: reset during beat1 aborts the request without done
        push_beat(32'h0, 32'd4, 0, 16'hFFFF, 1'b0);
        start_req(32'h0, 32'd4, 8'd20);
        tick();
        chk("t6_beat1_valid", out_valid, 1'b1);
        chk("t6_beat1_mask", lane_mask, 16'h000F);
        rst = 1;
        tick();
        chk("t6_busy", busy, 1'b0);
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_last", last, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_addr", addr, '0);
        chk("t6_mask", lane_mask, '0);
        rst = 0;
        tick();
        chk("t6_no_done", done, 1'b0);
        chk("t6_sb_empty", sb.size(), 0);

        // fresh request after the abort
        push_beat(32'h100, 32'd1, 0, 16'hFFFF, 1'b1);
        start_req(32'h100, 32'd1, 8'd16);
        wait_done("t6_fresh");
        chk("t6_fresh_sb_empty", sb.size(), 0);

        tick();
        chk("done_pulse_count", done_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
